// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm controller downstream of the 12-hour BCD time counter.
// Holds a programmable alarm time and runs an IDLE/ARMED/RINGING/SNOOZE
// state machine. The outputs are registered: ringing, snoozing and a 1 Hz
// gated buzz. A rejected alarm load produces a one-cycle set_err pulse.
module alarm_ctrl #(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       pm,
    input  logic       alarm_on,
    input  logic       set_en,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic       set_pm,
    input  logic       snooze,
    input  logic       stop,
    output logic [7:0] al_hh,
    output logic [7:0] al_mm,
    output logic       al_pm,
    output logic       set_err,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzz
);

    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

    localparam logic [15:0] RING_LIM = 16'(RING_SECS);
    localparam logic [15:0] SNZ_LIM  = 16'(SNOOZE_MIN * 60);

    state_t      state_q, state_d;
    logic [7:0]  al_hh_q, al_hh_d;
    logic [7:0]  al_mm_q, al_mm_d;
    logic        al_pm_q, al_pm_d;
    logic        set_err_q, set_err_d;
    logic        match_q, match_d;
    logic [15:0] ring_cnt_q, ring_cnt_d;
    logic [15:0] snz_cnt_q, snz_cnt_d;
    logic        beep_q, beep_d;
    logic        ringing_q, ringing_d;
    logic        snoozing_q, snoozing_d;
    logic        buzz_q, buzz_d;

    logic        hh_ok, mm_ok, match, trigger;

    // Alarm load: validate the BCD hour (01..12) and minute (00..59).
    always_comb begin
        hh_ok = ((set_hh[7:4] == 4'd0) && (set_hh[3:0] != 4'd0) && (set_hh[3:0] <= 4'd9)) ||
                ((set_hh[7:4] == 4'd1) && (set_hh[3:0] <= 4'd2));
        mm_ok = (set_mm[7:4] <= 4'd5) && (set_mm[3:0] <= 4'd9);
        al_hh_d   = al_hh_q;
        al_mm_d   = al_mm_q;
        al_pm_d   = al_pm_q;
        set_err_d = 1'b0;
        if (set_en) begin
            if (hh_ok && mm_ok) begin
                al_hh_d = set_hh;
                al_mm_d = set_mm;
                al_pm_d = set_pm;
            end else begin
                set_err_d = 1'b1;
            end
        end
    end

    // Rising-edge match detect. While disarmed the history is frozen, so
    // unknown time inputs cannot leak in, and re-arming inside the alarm
    // second does not count as a fresh match.
    always_comb begin
        match   = (hh == al_hh_q) && (mm == al_mm_q) && (pm == al_pm_q) && (ss == 8'h00);
        match_d = alarm_on ? match : match_q;
        trigger = match && !match_q;
    end

    // Next state, counters, beep phase and registered output values.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        beep_d     = beep_q;
        if (!alarm_on) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   if (trigger) state_d = RINGING;
                RINGING: begin
                    if (stop)        state_d = ARMED;
                    else if (snooze) state_d = SNOOZE;
                    else if (tick && (ring_cnt_q + 16'd1 == RING_LIM)) state_d = ARMED;
                end
                SNOOZE: begin
                    if (stop) state_d = ARMED;
                    else if (tick && (snz_cnt_q + 16'd1 == SNZ_LIM)) state_d = RINGING;
                end
                default: state_d = IDLE;
            endcase
        end
        // Any state change restarts the counters and the beep phase; a
        // stop/snooze always changes state, so a coincident tick is dropped.
        if (state_d != state_q) begin
            ring_cnt_d = 16'd0;
            snz_cnt_d  = 16'd0;
            beep_d     = 1'b1;
        end else if (state_q == RINGING && tick) begin
            ring_cnt_d = ring_cnt_q + 16'd1;
            beep_d     = !beep_q;
        end else if (state_q == SNOOZE && tick) begin
            snz_cnt_d = snz_cnt_q + 16'd1;
        end
        ringing_d  = (state_d == RINGING);
        snoozing_d = (state_d == SNOOZE);
        buzz_d     = ringing_d && beep_d;
    end

    // All state registers, asynchronously cleared by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            al_hh_q    <= 8'h12;
            al_mm_q    <= 8'h00;
            al_pm_q    <= 1'b0;
            set_err_q  <= 1'b0;
            match_q    <= 1'b0;
            ring_cnt_q <= 16'd0;
            snz_cnt_q  <= 16'd0;
            beep_q     <= 1'b1;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            buzz_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            al_hh_q    <= al_hh_d;
            al_mm_q    <= al_mm_d;
            al_pm_q    <= al_pm_d;
            set_err_q  <= set_err_d;
            match_q    <= match_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            beep_q     <= beep_d;
            ringing_q  <= ringing_d;
            snoozing_q <= snoozing_d;
            buzz_q     <= buzz_d;
        end
    end

    assign al_hh    = al_hh_q;
    assign al_mm    = al_mm_q;
    assign al_pm    = al_pm_q;
    assign set_err  = set_err_q;
    assign ringing  = ringing_q;
    assign snoozing = snoozing_q;
    assign buzz     = buzz_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl (RING_SECS=5, SNOOZE_MIN=1).
// Stimulus pushes the hand-computed output vector expected after the next
// clock edge; a monitor pops and compares on each falling edge, or at once
// when the stimulus fires chk_ev (used for the asynchronous reset check).
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset, tick, pm, alarm_on, set_en, set_pm, snooze, stop;
    logic [7:0] hh, mm, ss, set_hh, set_mm;
    logic [7:0] al_hh, al_mm;
    logic       al_pm, set_err, ringing, snoozing, buzz;

    always #5 clk = ~clk;

    alarm_ctrl #(.RING_SECS(5), .SNOOZE_MIN(1)) dut (
        .clk(clk), .reset(reset), .tick(tick), .hh(hh), .mm(mm), .ss(ss), .pm(pm),
        .alarm_on(alarm_on), .set_en(set_en), .set_hh(set_hh), .set_mm(set_mm),
        .set_pm(set_pm), .snooze(snooze), .stop(stop), .al_hh(al_hh), .al_mm(al_mm),
        .al_pm(al_pm), .set_err(set_err), .ringing(ringing), .snoozing(snoozing),
        .buzz(buzz)
    );

    typedef struct {
        int          due;
        string       name;
        logic [20:0] exp;
    } item_t;

    item_t sb_q[$];
    int    cyc   = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    done  = 0;
    event  chk_ev;

    // Expected outputs after the next edge, maintained by the stimulus.
    logic [7:0] e_hh = 8'h12, e_mm = 8'h00;
    logic       e_pm = 0, e_err = 0, e_ring = 0, e_snz = 0, e_buzz = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fmt(logic [20:0] v);
        return $sformatf("%h:%h pm=%b err=%b ring=%b snz=%b buzz=%b",
                         v[20:13], v[12:5], v[4], v[3], v[2], v[1], v[0]);
    endfunction

    task automatic push(string nm, int due);
        item_t it;
        it.due  = due;
        it.name = nm;
        it.exp  = {e_hh, e_mm, e_pm, e_err, e_ring, e_snz, e_buzz};
        sb_q.push_back(it);
    endtask

    task automatic step(string nm);
        push(nm, cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(string nm, logic [7:0] h, logic [7:0] m, logic p, bit ok);
        set_en = 1; set_hh = h; set_mm = m; set_pm = p;
        if (ok) begin
            e_hh = h; e_mm = m; e_pm = p;
        end
        e_err = !ok;
        step(nm);
        set_en = 0;
        e_err  = 0;
        step({nm, "_after"});
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    // Monitor: compare every due scoreboard entry against the DUT outputs.
    initial begin
        item_t       it;
        logic [20:0] act;
        forever begin
            @(negedge clk or chk_ev);
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                it  = sb_q.pop_front();
                act = {al_hh, al_mm, al_pm, set_err, ringing, snoozing, buzz};
                n_cmp++;
                if (act !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: got %s, want %s", it.name, cyc, fmt(act), fmt(it.exp));
                end else begin
                    $display("ok   %s @cyc %0d: %s", it.name, cyc, fmt(act));
                end
            end
        end
    end

    // Watchdog: the whole run must finish well inside this bound.
    initial begin
        #100000;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL watchdog: got no end of stimulus, want finish before 100000 ns");
            summary();
            $finish;
        end
    end

    // Stimulus
    initial begin
        reset = 0; tick = 0; alarm_on = 0; set_en = 0; snooze = 0; stop = 0;
        hh = 8'h01; mm = 8'h00; ss = 8'h01; pm = 0;
        set_hh = 8'h00; set_mm = 8'h00; set_pm = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;

        for (int i = 0; i < 20; i++) step("reset_hold");

        // Alarm loads, accepted and rejected
        do_load("load_0730pm", 8'h07, 8'h30, 1'b1, 1'b1);
        do_load("rej_hh13",    8'h13, 8'h30, 1'b1, 1'b0);
        do_load("rej_mm5a",    8'h07, 8'h5A, 1'b1, 1'b0);
        do_load("rej_hh00",    8'h00, 8'h30, 1'b1, 1'b0);
        do_load("load_1259am", 8'h12, 8'h59, 1'b0, 1'b1);
        do_load("load_0730pm2", 8'h07, 8'h30, 1'b1, 1'b1);

        // Arm, then hit 07:30:00 PM
        alarm_on = 1;
        step("arm");
        hh = 8'h07; mm = 8'h30; pm = 1; ss = 8'h59;
        step("pre_match");
        ss = 8'h00; e_ring = 1; e_buzz = 1;
        step("ring_start");
        for (int i = 0; i < 5; i++) step("ss00_held_no_tick");
        for (int t = 1; t <= 5; t++) begin
            tick = 1;
            if (t == 5) begin e_ring = 0; e_buzz = 0; end
            else e_buzz = (t % 2 == 0);
            step($sformatf("ring_tick%0d", t));
            tick = 0;
            step($sformatf("ring_gap%0d", t));
        end
        for (int i = 0; i < 6; i++) step("armed_no_retrigger");

        // Snooze, expiry back to ringing, snooze again, stop
        ss = 8'h01;
        step("ss01");
        ss = 8'h00; e_ring = 1; e_buzz = 1;
        step("ring2_start");
        snooze = 1; ss = 8'h01; e_ring = 0; e_buzz = 0; e_snz = 1;
        step("snooze");
        snooze = 0;
        for (int i = 1; i <= 60; i++) begin
            tick = 1;
            if (i == 60) begin e_snz = 0; e_ring = 1; e_buzz = 1; end
            step($sformatf("snz_tick%0d", i));
            tick = 0;
        end
        snooze = 1; e_ring = 0; e_buzz = 0; e_snz = 1;
        step("snooze2");
        snooze = 0;
        for (int i = 0; i < 3; i++) begin
            tick = 1;
            step("snooze2_tick");
            tick = 0;
            step("snooze2_gap");
        end
        stop = 1; e_snz = 0;
        step("stop_in_snooze");
        stop = 0;
        for (int i = 0; i < 70; i++) begin
            tick = (i % 2 == 0);
            step("armed_after_stop");
        end
        tick = 0;

        // stop and snooze together (with a tick) while ringing
        ss = 8'h00; e_ring = 1; e_buzz = 1;
        step("ring3_start");
        stop = 1; snooze = 1; tick = 1; e_ring = 0; e_buzz = 0; e_snz = 0;
        step("stop_snooze_same");
        stop = 0; snooze = 0; tick = 0; ss = 8'h01;
        step("after_stop_snooze");

        // Asynchronous reset between edges while ringing
        ss = 8'h00; e_ring = 1; e_buzz = 1;
        step("ring4_start");
        @(negedge clk);
        #2 reset = 0;
        #1;
        e_hh = 8'h12; e_mm = 8'h00; e_pm = 0; e_ring = 0; e_buzz = 0;
        push("async_reset_now", cyc);
        ->chk_ev;
        @(posedge clk);
        #1 reset = 1;
        step("post_reset_arm");
        for (int i = 0; i < 3; i++) step("post_reset_no_ring");

        // Reload the alarm while the time already reads 07:30:00 PM
        set_en = 1; set_hh = 8'h07; set_mm = 8'h30; set_pm = 1;
        e_hh = 8'h07; e_mm = 8'h30; e_pm = 1;
        step("reload_0730pm");
        set_en = 0; e_ring = 1; e_buzz = 1;
        step("ring_after_reload");

        // Drop alarm_on while ringing, re-raise inside the same second
        alarm_on = 0; e_ring = 0; e_buzz = 0;
        step("alarm_off_idle");
        for (int i = 0; i < 3; i++) step("idle_hold");
        alarm_on = 1;
        step("rearm_ss00");
        for (int i = 0; i < 5; i++) step("rearm_no_ring");

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
        end
        done = 1;
        summary();
        $finish;
    end

endmodule
